// File: rtl/silife_grid_pkg.sv
// Shared types and constants for the Game-of-Life grid block.
package silife_pkg;

  localparam int GRID_W = 8;
  localparam int GRID_H = 8;

  typedef logic [GRID_W-1:0] row_t;
  typedef row_t [GRID_H-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/silife_grid_if.sv
// Host row-write port: valid/ready handshake carrying a row index and its contents.
interface silife_grid_if;
  import silife_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  row_t       wr_data;

  modport master (output wr_valid, output wr_row, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_row, input wr_data, output wr_ready);

endinterface

// File: rtl/silife_grid_row_next.sv
// Next-generation value of one board row from the rows above, at and below it.
// Purely combinational; the grid time-multiplexes one instance over all rows.
module silife_row_next
  import silife_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  row_t above_i,
  input  row_t cur_i,
  input  row_t below_i,
  output row_t next_o
);

  // Column c of row r, folding out-of-range columns per the edge mode.
  function automatic logic bit_at(row_t r, int c);
    logic v;
    if (c < 0 || c >= GRID_W) v = WRAP ? r[3'(c)] : 1'b0;
    else                      v = r[3'(c)];
    return v;
  endfunction

  // Neighbour count (0..8) and the birth/survival rule for column c.
  function automatic logic cell_next(row_t a, row_t m, row_t b, int c);
    logic [3:0] n;
    n = {3'b0, bit_at(a, c - 1)} + {3'b0, bit_at(a, c)} + {3'b0, bit_at(a, c + 1)}
      + {3'b0, bit_at(m, c - 1)} + {3'b0, bit_at(m, c + 1)}
      + {3'b0, bit_at(b, c - 1)} + {3'b0, bit_at(b, c)} + {3'b0, bit_at(b, c + 1)};
    return (n == 4'd3) | (m[3'(c)] & (n == 4'd2));
  endfunction

  // Evaluate every column of the row in parallel.
  always_comb begin
    next_o = '0;
    for (int c = 0; c < GRID_W; c++) begin
      next_o[c] = cell_next(above_i, cur_i, below_i, c);
    end
  end

endmodule

// File: rtl/silife_grid.sv
// 8x8 Game-of-Life board with double buffering. The display port always reads
// the front buffer; a generation is built row-by-row into the back buffer and
// then copied to the front in one edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | board stable, host writes accepted, waiting for step/pending
// COMPUTE | one back-buffer row per cycle, rows 0..7
// COMMIT  | front := back, generation count advances
module silife_grid
  import silife_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  silife_grid_if.slave wr,
  input  logic [2:0]   row_select,
  output row_t         cells,
  output logic         busy,
  output logic         gen_done,
  output logic [15:0]  generation
);

  state_t      state_q;
  logic [2:0]  row_q;
  logic        pending_q;
  logic        busy_q;
  logic        gen_done_q;
  logic [15:0] gen_q;
  grid_t       front_q;
  grid_t       back_q;

  row_t        above_d;
  row_t        below_d;
  row_t        next_d;

  // Neighbour rows of the row being computed; vertical edges wrap or read as dead.
  always_comb begin
    above_d = front_q[row_q - 3'd1];
    below_d = front_q[row_q + 3'd1];
    if (!WRAP && row_q == 3'd0) above_d = '0;
    if (!WRAP && row_q == 3'd7) below_d = '0;
  end

  silife_row_next #(.WRAP(WRAP)) u_row_next (
    .above_i (above_d),
    .cur_i   (front_q[row_q]),
    .below_i (below_d),
    .next_o  (next_d)
  );

  assign cells       = front_q[row_select];
  assign busy        = busy_q;
  assign gen_done    = gen_done_q;
  assign generation  = gen_q;
  assign wr.wr_ready = ~busy_q;

  // Sequencer: host writes and step launch in IDLE, row sweep, single-edge commit.
  // A step seen while busy is remembered once in pending_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      gen_done_q <= 1'b0;
      gen_q      <= '0;
      front_q    <= '0;
      back_q     <= '0;
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr.wr_valid) front_q[wr.wr_row] <= wr.wr_data;
          if (step || pending_q) begin
            state_q   <= COMPUTE;
            row_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        COMPUTE: begin
          back_q[row_q] <= next_d;
          row_q         <= row_q + 3'd1;
          if (step) pending_q <= 1'b1;
          if (row_q == 3'd7) state_q <= COMMIT;
        end
        COMMIT: begin
          front_q    <= back_q;
          gen_q      <= gen_q + 16'd1;
          gen_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
          if (step) pending_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
